// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: turns a priority-encoded request into a CPU
// req/ack/done handshake with source clear, hold-off and statistics.
module irq_dispatch #(
    parameter int N_SRC   = 8,
    parameter int IDW     = 3,
    parameter int HOLDOFF = 4,
    parameter int CNTW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_valid,
    input  logic [IDW-1:0]   enc_code,
    output logic             irq_req,
    output logic [IDW-1:0]   irq_id,
    input  logic             irq_ack,
    input  logic             irq_done,
    output logic [N_SRC-1:0] clr_pulse,
    output logic             busy,
    output logic [CNTW-1:0]  serviced_cnt,
    output logic [CNTW-1:0]  spurious_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_SVC  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int HW = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam int HL = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [HW-1:0] HLOAD = HW'(HL);

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_id;
    logic [HW-1:0]    r_hold;
    logic [N_SRC-1:0] r_clr;
    logic             r_req;
    logic             r_busy;
    logic [CNTW-1:0]  r_serv;
    logic [CNTW-1:0]  r_spur;

    logic [1:0]       w_next;
    logic [IDW-1:0]   w_id;
    logic [HW-1:0]    w_hold;
    logic [N_SRC-1:0] w_clr;
    logic             w_serv_inc;
    logic             w_spur_inc;

    // Inside REQ the ack test comes first, so it beats retarget and withdrawal
    always_comb begin
        w_next     = r_state;
        w_id       = r_id;
        w_hold     = r_hold;
        w_clr      = '0;
        w_serv_inc = 1'b0;
        w_spur_inc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (enc_valid) begin
                    w_id   = enc_code;
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    w_next     = S_SVC;
                    w_clr      = N_SRC'(1) << r_id;
                    w_serv_inc = 1'b1;
                end else if (enc_valid) begin
                    if (enc_code > r_id) begin
                        w_id = enc_code;
                    end
                end else begin
                    w_next     = S_IDLE;
                    w_spur_inc = 1'b1;
                end
            end
            S_SVC: begin
                if (irq_done) begin
                    if (HOLDOFF == 0) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_HOLD;
                        w_hold = HLOAD;
                    end
                end
            end
            S_HOLD: begin
                if (r_hold == '0) begin
                    w_next = S_IDLE;
                end else begin
                    w_hold = r_hold - 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_hold  <= '0;
            r_clr   <= '0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_serv  <= '0;
            r_spur  <= '0;
        end else begin
            r_state <= w_next;
            r_id    <= w_id;
            r_hold  <= w_hold;
            r_clr   <= w_clr;
            r_req   <= (w_next == S_REQ);
            r_busy  <= (w_next != S_IDLE);
            if (w_serv_inc && !(&r_serv)) begin
                r_serv <= r_serv + 1'b1;
            end
            if (w_spur_inc && !(&r_spur)) begin
                r_spur <= r_spur + 1'b1;
            end
        end
    end

    assign irq_req      = r_req;
    assign irq_id       = r_id;
    assign clr_pulse    = r_clr;
    assign busy         = r_busy;
    assign serviced_cnt = r_serv;
    assign spurious_cnt = r_spur;

endmodule

// File: tb/tb_irq_dispatch.sv
// Randomized scoreboard bench for irq_dispatch (HOLDOFF=4 instance)
// plus a directed check of a HOLDOFF=0 instance.
module tb_irq_dispatch;

    localparam int HO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       enc_valid;
    logic [2:0] enc_code;
    logic       irq_req;
    logic [2:0] irq_id;
    logic       irq_ack;
    logic       irq_done;
    logic [7:0] clr_pulse;
    logic       busy;
    logic [7:0] serviced_cnt;
    logic [7:0] spurious_cnt;

    logic       b_enc_valid;
    logic [2:0] b_enc_code;
    logic       b_irq_req;
    logic [2:0] b_irq_id;
    logic       b_irq_ack;
    logic       b_irq_done;
    logic [7:0] b_clr_pulse;
    logic       b_busy;
    logic [7:0] b_serviced_cnt;
    logic [7:0] b_spurious_cnt;

    irq_dispatch #(.N_SRC(8), .IDW(3), .HOLDOFF(HO), .CNTW(8)) dut (
        .clk(clk), .rst(rst),
        .enc_valid(enc_valid), .enc_code(enc_code),
        .irq_req(irq_req), .irq_id(irq_id),
        .irq_ack(irq_ack), .irq_done(irq_done),
        .clr_pulse(clr_pulse), .busy(busy),
        .serviced_cnt(serviced_cnt), .spurious_cnt(spurious_cnt)
    );

    irq_dispatch #(.N_SRC(8), .IDW(3), .HOLDOFF(0), .CNTW(8)) dut_b (
        .clk(clk), .rst(rst),
        .enc_valid(b_enc_valid), .enc_code(b_enc_code),
        .irq_req(b_irq_req), .irq_id(b_irq_id),
        .irq_ack(b_irq_ack), .irq_done(b_irq_done),
        .clr_pulse(b_clr_pulse), .busy(b_busy),
        .serviced_cnt(b_serviced_cnt), .spurious_cnt(b_spurious_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] exp_id_q[$];
    logic [7:0] exp_clr_q[$];
    logic [7:0] exp_srv_q[$];
    int exp_serv = 0;
    int exp_spur = 0;

    logic       prev_req = 1'b0;
    logic [2:0] prev_id  = 3'd0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    task automatic miss(input string nm, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected at %0t", nm, act,
                 $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every newly presented id and every clear pulse is matched
    // against the scoreboard queues filled by the stimulus side.
    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (irq_req && (!prev_req || irq_id != prev_id)) begin
                if (exp_id_q.size() == 0) miss("irq_id", 32'(irq_id));
                else chk("irq_id", 32'(irq_id), 32'(exp_id_q.pop_front()));
            end
            if (clr_pulse != 8'd0) begin
                chk("clr_onehot", $countones(clr_pulse), 1);
                if (exp_clr_q.size() == 0) begin
                    miss("clr_pulse", 32'(clr_pulse));
                end else begin
                    chk("clr_pulse", 32'(clr_pulse),
                        32'(exp_clr_q.pop_front()));
                    chk("serviced_cnt", 32'(serviced_cnt),
                        32'(exp_srv_q.pop_front()));
                end
            end
            prev_req = irq_req;
            prev_id  = irq_id;
        end
    end

    // One request lifetime. Expected id is the highest code seen in REQ
    // (up to the ack); an ack clears exactly that source.
    task automatic txn(input logic [2:0] c, input int rt, input int nret,
                       input bit wd, input int adly, input bit hi_at_ack,
                       input int ddly);
        logic [2:0] id;
        logic [2:0] r;
        id = c;
        enc_valid = 1'b1;
        enc_code  = c;
        exp_id_q.push_back(c);
        step();
        chk("req_latency", 32'(irq_req), 1);
        chk("busy_req", 32'(busy), 1);
        if (rt >= 0) begin
            r = 3'(rt);
            enc_code = r;
            if (r > id) begin
                id = r;
                exp_id_q.push_back(r);
            end
            step();
            chk("retarget_no_gap", 32'(irq_req), 1);
        end
        for (int k = 0; k < nret; k++) begin
            r = 3'($urandom_range(0, 7));
            enc_code = r;
            if (r > id) begin
                id = r;
                exp_id_q.push_back(r);
            end
            step();
            chk("req_no_gap", 32'(irq_req), 1);
        end
        for (int k = 0; k < adly; k++) begin
            enc_code = 3'($urandom_range(0, 32'(id)));
            step();
            chk("req_held", 32'(irq_req), 1);
        end
        if (wd) begin
            enc_valid = 1'b0;
            step();
            if (exp_spur < 255) exp_spur++;
            chk("withdraw_req", 32'(irq_req), 0);
            chk("withdraw_busy", 32'(busy), 0);
            chk("spurious_cnt", 32'(spurious_cnt), 32'(exp_spur));
            return;
        end
        irq_ack  = 1'b1;
        enc_code = hi_at_ack ? 3'd7 : 3'($urandom_range(0, 7));
        if (exp_serv < 255) exp_serv++;
        exp_clr_q.push_back(8'(1) << id);
        exp_srv_q.push_back(8'(exp_serv));
        step();
        irq_ack = 1'b0;
        chk("svc_req_low", 32'(irq_req), 0);
        chk("svc_id_hold", 32'(irq_id), 32'(id));
        enc_valid = hi_at_ack ? 1'b1 : 1'($urandom_range(0, 1));
        enc_code  = hi_at_ack ? 3'd7 : 3'($urandom_range(0, 7));
        for (int k = 0; k < ddly; k++) begin
            irq_ack = 1'($urandom_range(0, 1));
            step();
            chk("svc_busy", 32'(busy), 1);
            chk("svc_req_low2", 32'(irq_req), 0);
        end
        irq_ack  = 1'b0;
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        for (int i = 0; i < HO; i++) begin
            if (i == HO - 1) enc_valid = 1'b0;
            step();
            chk("holdoff_busy", 32'(busy), 32'(i < HO - 1));
            chk("hold_req_low", 32'(irq_req), 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        enc_valid = 1'b0; enc_code = 3'd0; irq_ack = 1'b0; irq_done = 1'b0;
        b_enc_valid = 1'b0; b_enc_code = 3'd0;
        b_irq_ack = 1'b0; b_irq_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(irq_req), 0);
        chk("rst_id", 32'(irq_id), 0);
        chk("rst_clr", 32'(clr_pulse), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_serv", 32'(serviced_cnt), 0);
        chk("rst_spur", 32'(spurious_cnt), 0);
        rst = 1'b0;
        step();

        txn(3'd5, -1, 0, 1'b0, 2, 1'b0, 2);
        chk("basic_serv", 32'(serviced_cnt), 1);
        txn(3'd2, 6, 0, 1'b0, 1, 1'b0, 1);
        txn(3'd3, -1, 0, 1'b0, 0, 1'b1, 0);
        txn(3'd7, -1, 0, 1'b0, 0, 1'b0, 0);
        txn(3'd4, -1, 0, 1'b1, 1, 1'b0, 0);
        chk("withdraw_clr", 32'(clr_pulse), 0);

        for (int n = 0; n < 40; n++) begin
            txn(3'($urandom_range(0, 7)), -1, $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0,
                $urandom_range(0, 3));
        end

        enc_valid = 1'b1;
        enc_code  = 3'd1;
        exp_id_q.push_back(3'd1);
        step();
        irq_ack = 1'b1;
        if (exp_serv < 255) exp_serv++;
        exp_clr_q.push_back(8'h02);
        exp_srv_q.push_back(8'(exp_serv));
        step();
        irq_ack   = 1'b0;
        enc_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(irq_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_clr", 32'(clr_pulse), 0);
        chk("arst_id", 32'(irq_id), 0);
        chk("arst_serv", 32'(serviced_cnt), 0);
        chk("arst_spur", 32'(spurious_cnt), 0);
        exp_serv = 0;
        exp_spur = 0;
        step();
        rst = 1'b0;
        step();
        txn(3'd5, -1, 0, 1'b0, 2, 1'b0, 2);
        chk("post_rst_serv", 32'(serviced_cnt), 1);

        for (int n = 0; n < 260; n++) begin
            txn(3'($urandom_range(0, 7)), -1, 0, 1'b0, 0, 1'b0, 0);
        end
        chk("serv_saturate", 32'(serviced_cnt), 32'(exp_serv));
        chk("serv_is_255", 32'(serviced_cnt), 255);

        b_enc_valid = 1'b1;
        b_enc_code  = 3'd4;
        step();
        chk("b_req", 32'(b_irq_req), 1);
        chk("b_id", 32'(b_irq_id), 4);
        b_irq_ack = 1'b1;
        step();
        b_irq_ack  = 1'b0;
        b_enc_code = 3'd6;
        chk("b_clr", 32'(b_clr_pulse), 32'h10);
        b_irq_done = 1'b1;
        step();
        b_irq_done = 1'b0;
        chk("b_t1_req", 32'(b_irq_req), 0);
        chk("b_t1_busy", 32'(b_busy), 0);
        step();
        chk("b_t2_req", 32'(b_irq_req), 1);
        chk("b_t2_id", 32'(b_irq_id), 6);
        b_enc_valid = 1'b0;
        step();

        chk("id_q_empty", exp_id_q.size(), 0);
        chk("clr_q_empty", exp_clr_q.size(), 0);
        chk("spur_final", 32'(spurious_cnt), 32'(exp_spur));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
